// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: bus data width and FSM state encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mem_responder_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = XLEN / 8;

    // 2-bit state encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

endpackage

// File: rtl/mem_responder_be_ram.sv
// Single-port byte-write-enabled RAM: synchronous write, combinational read.
// Latency: read is combinational; write lands on the rising edge where i_we is high.
// Backpressure: none, always ready. Contents are never reset.
// Ports: i_clk clock; i_we write enable; i_be byte strobes; i_addr word index;
//        i_wdata write word; o_rdata word currently stored at i_addr.
module be_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [DATA_W/8-1:0]   i_be,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (i_be[b]) begin
                    mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: latches a bus request, waits LATENCY cycles, then acks with read data / error.
// Latency: o_ack exactly LATENCY+1 cycles after the request is sampled in IDLE; one RECOVER cycle follows.
// Backpressure: initiator holds i_bus_en until o_ack; dropping it during WAIT aborts the request.
// Ports: i_clk/i_rst (sync, active-low); i_bus_en/i_wr_en/i_addr/i_wr_data/i_byte_en request;
//        o_ack completion pulse, o_rd_data read data (held between acks), o_err out-of-range, o_busy not IDLE.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2     // legal range 0..15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_bus_en,
    input  logic             i_wr_en,
    input  logic [XLEN-1:0]  i_addr,
    input  logic [XLEN-1:0]  i_wr_data,
    input  logic [BE_W-1:0]  i_byte_en,
    output logic             o_ack,
    output logic [XLEN-1:0]  o_rd_data,
    output logic             o_err,
    output logic             o_busy
);

    // With zero latency the WAIT state is skipped entirely.
    localparam logic [1:0] FIRST_ST = (LATENCY > 0) ? ST_WAIT : ST_ACK;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [1:0]      state_q,   state_d;
    logic [3:0]      cnt_q,     cnt_d;
    logic            wr_q,      wr_d;
    logic [XLEN-1:0] addr_q,    addr_d;
    logic [XLEN-1:0] wdata_q,   wdata_d;
    logic [BE_W-1:0] be_q,      be_d;
    logic [XLEN-1:0] rd_hold_q, rd_hold_d;

    logic            oor;
    logic            ram_we;
    logic [XLEN-1:0] ram_rdata;
    logic [XLEN-1:0] ack_rdata;

    // Any address bit above the word index makes the access out of range.
    assign oor       = |(addr_q >> (DEPTH_LOG2 + 2));
    assign ack_rdata = oor ? '0 : ram_rdata;

    // Write commits on the edge that ends ACK; a reset sampled on that edge suppresses it.
    assign ram_we = (state_q == ST_ACK) && wr_q && !oor && i_rst;

    be_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (XLEN)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_be    (be_q),
        .i_addr  (addr_q[DEPTH_LOG2+1:2]),
        .i_wdata (wdata_q),
        .o_rdata (ram_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rd_hold_d = rd_hold_q;

        case (state_q)
            ST_IDLE: begin
                if (i_bus_en) begin
                    wr_d    = i_wr_en;
                    addr_d  = i_addr;
                    wdata_d = i_wr_data;
                    be_d    = i_byte_en;
                    cnt_d   = CNT_INIT;
                    state_d = FIRST_ST;
                end
            end
            ST_WAIT: begin
                if (!i_bus_en) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                // Capture what the initiator saw so o_rd_data holds between acks.
                rd_hold_d = ack_rdata;
                state_d   = ST_RECOVER;
            end
            ST_RECOVER: begin
                // Initiator still has bus_en high this cycle; do not resample it.
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rd_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rd_hold_q <= rd_hold_d;
        end
    end

    assign o_ack     = (state_q == ST_ACK);
    assign o_err     = o_ack && oor;
    assign o_rd_data = o_ack ? ack_rdata : rd_hold_q;
    assign o_busy    = (state_q != ST_IDLE);

endmodule
